// File: rtl/fork_with_flow_control.sv
// fork_with_flow_control: splits one valid/ready stream of 2*WIDTH-bit words into
// two independently drained WIDTH-bit streams, each with its own FIFO.
module fork_fifo #(
  parameter int W = 4,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         full_o
);
  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pop;
  assign vld_o  = cnt_q != '0;
  assign full_o = cnt_q == CW'(D);
  assign data_o = mem_q[rp_q];
  assign pop    = vld_o & rdy_i;
  always_comb begin
    wp_d  = push_i ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: counts gate visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= data_i;
  end
endmodule

module fork_with_flow_control #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               a_vld,
  input  logic               a_rdy,
  output logic [WIDTH-1:0]   a_data,
  output logic               b_vld,
  input  logic               b_rdy,
  output logic [WIDTH-1:0]   b_data
);
  logic a_full, b_full, push;
  // Ready depends on registered fullness only, so a full FIFO popping still stalls one cycle.
  assign in_rdy = ~a_full & ~b_full;
  assign push   = in_vld & in_rdy;
  fork_fifo #(.W(WIDTH), .D(DEPTH)) u_a (
    .clk(clk), .rst_n(rst_n), .push_i(push), .data_i(in_data[WIDTH-1:0]),
    .rdy_i(a_rdy), .vld_o(a_vld), .data_o(a_data), .full_o(a_full)
  );
  fork_fifo #(.W(WIDTH), .D(DEPTH)) u_b (
    .clk(clk), .rst_n(rst_n), .push_i(push), .data_i(in_data[2*WIDTH-1:WIDTH]),
    .rdy_i(b_rdy), .vld_o(b_vld), .data_o(b_data), .full_o(b_full)
  );
endmodule

// File: tb/tb_fork_with_flow_control.sv
// tb_fork_with_flow_control: directed stimulus with a queue scoreboard per output.
module tb_fork_with_flow_control;
  logic clk = 0, rst_n = 0, in_vld = 0, a_rdy = 0, b_rdy = 0;
  logic [7:0] in_data = '0;
  logic in_rdy, a_vld, b_vld;
  logic [3:0] a_data, b_data;
  logic [3:0] qa[$], qb[$];
  int n_chk = 0, n_fail = 0;

  fork_with_flow_control #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every transfer seen on A or B is compared against its queue head.
  always @(negedge clk) begin
    if (rst_n && a_vld && a_rdy) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_extra: got %h expected nothing", a_data);
      end else check("a_data", a_data, qa.pop_front());
    end
    if (rst_n && b_vld && b_rdy) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_extra: got %h expected nothing", b_data);
      end else check("b_data", b_data, qb.pop_front());
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [7:0] d, input logic [3:0] ea, input logic [3:0] eb);
    bit done = 0;
    in_vld = 1;
    in_data = d;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (in_rdy) begin
        qa.push_back(ea);
        qb.push_back(eb);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_vld = 0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    in_vld = 1; in_data = 8'hA5; a_rdy = 1; b_rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_vld", a_vld, 0);
    check("rst_b_vld", b_vld, 0);
    check("rst_in_rdy", in_rdy, 1);
    rst_n = 1; in_vld = 0;
    cyc(1);
    check("rst_no_write_a", a_vld, 0);
    check("rst_no_write_b", b_vld, 0);

    send(8'h3C, 4'hC, 4'h3);
    @(negedge clk);
    check("lat_a_vld", a_vld, 1);
    check("lat_b_vld", b_vld, 1);
    @(posedge clk); #1;
    check("drained_a", a_vld, 0);
    check("drained_b", b_vld, 0);

    a_rdy = 0; b_rdy = 0;
    send(8'h21, 4'h1, 4'h2);
    send(8'h43, 4'h3, 4'h4);
    check("full_in_rdy", in_rdy, 0);
    a_rdy = 1;
    cyc(3);
    check("a_ahead_a_vld", a_vld, 0);
    check("a_ahead_b_vld", b_vld, 1);
    check("b_full_in_rdy", in_rdy, 0);
    b_rdy = 1;
    cyc(1);
    check("b_pop_in_rdy", in_rdy, 1);
    cyc(2);

    a_rdy = 0; b_rdy = 1;
    send(8'h65, 4'h5, 4'h6);
    send(8'h87, 4'h7, 4'h8);
    a_rdy = 1; in_vld = 1; in_data = 8'h9B;
    @(negedge clk);
    check("bubble_in_rdy", in_rdy, 0);
    @(negedge clk);
    check("after_bubble_in_rdy", in_rdy, 1);
    if (in_rdy) begin
      qa.push_back(4'hB);
      qb.push_back(4'h9);
    end
    @(posedge clk); #1;
    in_vld = 0;
    cyc(4);
    check("mid_qa_empty", qa.size(), 0);
    check("mid_qb_empty", qb.size(), 0);

    a_rdy = 0;
    fork
      for (int i = 0; i < 16; i++) send(8'(i), 4'(i), 4'h0);
      repeat (120) begin
        @(posedge clk); #1;
        a_rdy = ~a_rdy;
        b_rdy = 1'($urandom_range(0, 1));
      end
    join
    a_rdy = 1; b_rdy = 1;
    cyc(6);
    check("stream_qa_empty", qa.size(), 0);
    check("stream_qb_empty", qb.size(), 0);

    a_rdy = 0; b_rdy = 0;
    send(8'h11, 4'h1, 4'h1);
    send(8'h22, 4'h2, 4'h2);
    b_rdy = 1;
    cyc(1);
    b_rdy = 0;
    rst_n = 0;
    cyc(1);
    check("mid_rst_a_vld", a_vld, 0);
    check("mid_rst_b_vld", b_vld, 0);
    check("mid_rst_in_rdy", in_rdy, 1);
    qa.delete();
    qb.delete();
    rst_n = 1; a_rdy = 1; b_rdy = 1;
    send(8'h5A, 4'hA, 4'h5);
    cyc(4);
    check("final_qa_empty", qa.size(), 0);
    check("final_qb_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fork_with_flow_control.md
Name: fork_with_flow_control

Overview:
- Dual of the two-input join: one valid/ready input stream is forked into two independent valid/ready output streams, A and B.
- Each input word of 2*WIDTH bits is split: the low WIDTH bits go to A and the high WIDTH bits go to B.
- Each output has its own small FIFO, so the A and B consumers may drain at different rates.
- Sits in front of two independent consumers, for example to feed the a/b operand ports of a joined adder from a single packed stream.

Parameters:
- WIDTH, 4, width of each output field; the input word is 2*WIDTH bits.
- DEPTH, 2, entries per output FIFO; must be a power of two and >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_vld  input  1  input word valid.
- in_rdy  output  1  block can accept the input word.
- in_data  input  2*WIDTH  packed word: [WIDTH-1:0] goes to A, [2*WIDTH-1:WIDTH] goes to B.
- a_vld  output  1  A FIFO not empty.
- a_rdy  input  1  A consumer accepts.
- a_data  output  WIDTH  A FIFO head.
- b_vld  output  1  B FIFO not empty.
- b_rdy  input  1  B consumer accepts.
- b_data  output  WIDTH  B FIFO head.

Behaviour:
- Reset:
  - rst_n sampled low at a clock edge clears both FIFOs: pointers = 0, counts = 0.
  - After that edge: a_vld = b_vld = 0, in_rdy = 1.
  - a_data/b_data are don't-care while the corresponding vld is 0.
  - Reset mid-operation discards all buffered entries, including half-drained words where A was already taken but B was not.
- Push:
  - push = in_vld & in_rdy.
  - in_rdy = ~a_full & ~b_full, decoded from registered counts only.
  - No combinational path from a_rdy, b_rdy or in_vld to in_rdy.
  - On a push, the low field is written to A and the high field to B in the same cycle. Both halves of a word are always enqueued together.
- Pop:
  - pop_a = a_vld & a_rdy; pop_b = b_vld & b_rdy; the two are independent.
  - a_vld/a_data and b_vld/b_data come only from registers (FIFO head); no combinational input-to-output path.
- Latency: a word pushed at edge N is visible on a_data/b_data with vld = 1 after edge N (in cycle N+1), provided that FIFO was empty.
- Full FIFO:
  - When either FIFO holds DEPTH entries, in_rdy = 0, even if that FIFO pops in the same cycle.
  - This is a deliberate one-cycle bubble that keeps the ready path registered.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged; head advances; new entry is written at the tail.
- Empty FIFO: vld = 0; a consumer asserting rdy has no effect.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering:
  - Each output preserves input order.
  - A may run up to DEPTH words ahead of B, and vice versa.
- Protocol obligations:
  - Once a_vld or b_vld rises, it stays high and its data stays stable until popped.
  - in_data is captured only on a push.
  - The block tolerates in_vld dropping without a transfer.

Test Plan:
- Reset with in_vld = 1, in_data = 8'hA5 held during rst_n = 0 → a_vld = b_vld = 0, in_rdy = 1; no entry is written.
- Single word 8'h3C, a_rdy = b_rdy = 1 → one cycle later a_data = 4'hC and b_data = 4'h3, both vld = 1; both FIFOs are empty after the pop.
- a_rdy = b_rdy = 0; push 8'h21, 8'h43 → in_rdy = 0 after the second push. Then a_rdy = 1 only → A yields 1 then 3, B still holds 2 and 4, and in_rdy stays 0 until B drains one entry.
- Full FIFO with simultaneous pop_a and in_vld → in_rdy = 0 that cycle and no push occurs; the next cycle in_rdy = 1.
- Stream 16 words 8'h00..8'h0F (low = i, high = 0), with a_rdy toggling every cycle and b_rdy pseudo-random → A receives 0..F in order, B receives sixteen 0s, with no loss or duplication; pointer wrap is exercised.
- Reset asserted while A holds 2 entries and B holds 1 → vld = 0 the cycle after the reset edge; a subsequent push of 8'h5A delivers exactly 4'hA and 4'h5.
